// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state enum, default parameters and helpers for the PLL reset sequencer
package pll_seq_pkg;

    // Sequencer states, in the order they are visited after lock is acquired
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_HOLD_CYCLES   = 16;
    localparam int unsigned DEF_CEN_DIV       = 4;
    localparam logic [7:0]  LOST_MAX          = 8'hFF;

    // Saturating increment for the 8-bit lock-loss counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == LOST_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the asynchronous input through two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - holds the core in reset until the PLL lock has been stable, then runs
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned CEN_DIV       = DEF_CEN_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       sw_reset,
    output logic       rst_out,
    output logic       ready,
    output logic       cen,
    output logic [7:0] lost_count
);

    // +1 keeps the width non-zero when a count parameter is 1
    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DCW = $clog2(CEN_DIV);

    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_CYCLES - 1);
    localparam logic [DCW-1:0] DIV_LAST    = DCW'(CEN_DIV - 1);
    // cen is registered, so it is armed one cycle before the divider wraps
    localparam logic [DCW-1:0] DIV_FIRE    = DCW'(CEN_DIV - 2);

    logic           lock_s;
    logic           lock_lost;

    pll_state_e     state_q, state_d;
    logic [SCW-1:0] stable_cnt_q, stable_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DCW-1:0] div_q, div_d;
    logic           rst_out_q, rst_out_d;
    logic           ready_q, ready_d;
    logic           cen_q, cen_d;
    logic [7:0]     lost_q, lost_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (lock),
        .q   (lock_s)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            stable_cnt_q <= '0;
            hold_cnt_q   <= '0;
            div_q        <= '0;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            cen_q        <= 1'b0;
            lost_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            div_q        <= div_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            cen_q        <= cen_d;
            lost_q       <= lost_d;
        end
    end

    // Next state and phase counters; soft restart overrides any lock event
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        lock_lost    = 1'b0;
        if (sw_reset) begin
            state_d      = ST_WAIT_LOCK;
            stable_cnt_d = '0;
            hold_cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    stable_cnt_d = '0;
                    hold_cnt_d   = '0;
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d      = ST_WAIT_LOCK;
                        stable_cnt_d = '0;
                    end else if (stable_cnt_q == STABLE_LAST) begin
                        state_d      = ST_HOLD;
                        stable_cnt_d = '0;
                        hold_cnt_d   = '0;
                    end else begin
                        stable_cnt_d = stable_cnt_q + SCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_d    = ST_WAIT_LOCK;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HCW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d   = ST_WAIT_LOCK;
                        lock_lost = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they change on the same edge as the state
    always_comb begin
        rst_out_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        lost_d    = lock_lost ? sat_inc8(lost_q) : lost_q;
        div_d     = '0;
        if (state_q == ST_RUN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DCW'(1);
        end
        cen_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (div_q == DIV_FIRE);
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign cen        = cen_q;
    assign lost_count = lost_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: cycles lock must stay high before hold phase begins (range 1..65535).
REQ-002 Parameter HOLD_CYCLES, default 16: extra cycles rst_out stays asserted after stability is confirmed (range 1..255).
REQ-003 Parameter CEN_DIV, default 4: clock-enable division ratio (range 2..255).
REQ-004 Port clk  input  1  system clock, the PLL clkout; all logic is on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port lock  input  1  PLL lock flag, asynchronous to clk.
REQ-007 Port sw_reset  input  1  synchronous soft restart request, active-high, sampled each clk edge.
REQ-008 Port rst_out  output  1  active-high reset for the downstream core; asserts asynchronously, deasserts synchronously.
REQ-009 Port ready  output  1  high only in RUN.
REQ-010 Port cen  output  1  one-cycle clock-enable pulse every CEN_DIV cycles, in RUN only.
REQ-011 Port lost_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-012 lock shall pass through a 2-flop synchronizer; lock_s is the second flop's output.
REQ-013 The FSM shall have four states: WAIT_LOCK, STABLE, HOLD and RUN.
REQ-014 WAIT_LOCK: rst_out=1, ready=0; go to STABLE when lock_s=1, with the stability counter cleared.
REQ-015 STABLE: rst_out=1; the counter increments each cycle; go to HOLD after exactly STABLE_CYCLES cycles in STABLE; lock_s=0 returns to WAIT_LOCK and clears the counter.
REQ-016 HOLD: rst_out=1; go to RUN after exactly HOLD_CYCLES cycles; lock_s=0 returns to WAIT_LOCK.
REQ-017 RUN: rst_out=0, ready=1; lock_s=0 goes to WAIT_LOCK and increments lost_count, saturating at 255.
REQ-018 rst_out and ready shall be registered outputs decoded from the registered state.
REQ-019 Latency from lock high to rst_out low: take the first edge sampling lock=1 as edge 0; rst_out shall fall after edge 2+STABLE_CYCLES+HOLD_CYCLES.
REQ-020 Latency from lock loss to rst_out high: take the first edge sampling lock=0 as edge 0; rst_out shall rise after edge 2.
REQ-021 A lock low pulse of at least 2 clk periods shall always be detected; shorter pulses may be missed.
REQ-022 sw_reset=1 in any state shall force WAIT_LOCK on the next edge without incrementing lost_count.
REQ-023 If sw_reset and a lock loss occur on the same edge, sw_reset takes priority and lost_count does not increment.
REQ-024 cen divider: cleared on RUN entry; the first cen pulse occurs on the CEN_DIV-th cycle of RUN, then repeats every CEN_DIV cycles; cen=0 outside RUN.
REQ-025 Counters shall be sized by $clog2 of their parameters and shall never wrap while in use.

Reset
REQ-026 reset=1 shall immediately force: state=WAIT_LOCK, rst_out=1, ready=0, cen=0, lost_count=0, synchronizer flops=0, all counters=0.
REQ-027 Reset asserted mid-sequence, in any state, shall restart the full sequence from WAIT_LOCK after release.

Structure
REQ-028 The shared package pll_seq_pkg shall hold the state enum and the default parameter constants.
REQ-029 The synchronizer shall be one sub-module, sync_2ff, reused for lock.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4, CEN_DIV=4)
REQ-030 Release reset with lock=1 -> rst_out=1 through edge 13, rst_out=0 and ready=1 after edge 14.
REQ-031 lock drops for 1 cycle during STABLE -> at most one restart, and rst_out never falls before a full 8+4 window with lock held high.
REQ-032 In RUN, lock=0 for 3 cycles -> rst_out=1 after edge 2, lost_count=1, and the sequence re-runs when lock returns.
REQ-033 Cause 300 lock losses in RUN -> lost_count holds at 255.
REQ-034 In RUN -> cen pulses on RUN cycles 4, 8, 12, and cen=0 in every other state.
REQ-035 Assert sw_reset and a lock loss on the same edge, then assert reset mid-HOLD -> WAIT_LOCK, lost_count unchanged, rst_out=1 immediately and asynchronously.
